rgf_led_pwm: RTL and testbench

Parametrised LED register file with an integrated per-channel PWM/pattern engine; next generation of the fixed two-LED control RGF. Sits on the same bus interface behind the address decoder, holds software-written shadow configuration for NUM_CH channels, and applies it atomically on a commit at a PWM period boundary. Drives NUM_CH registered LED outputs in static, PWM, blink or breathe mode.

---
 rtl/rgf_led_pwm_pkg.sv | 46 ++++
 rtl/led_pwm_engine.sv | 105 ++++++++++
 rtl/rgf_led_pwm.sv | 157 +++++++++++++++
 tb/tb_rgf_led_pwm.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgf_led_pwm_pkg.sv
// Shared register map, field positions, LED mode encoding and register layouts for the LED RGF.
// Latency and backpressure: not applicable; this package holds declarations only.
package rgf_led_pwm_pkg;

  localparam int ADDR_CTRL    = 'h00;
  localparam int ADDR_PRESC   = 'h04;
  localparam int ADDR_STATUS  = 'h08;
  localparam int ADDR_CH_BASE = 'h10;
  localparam int CH_STRIDE    = 4;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_COMMIT_BIT = 1;
  localparam int CTRL_MODE_LSB   = 2;
  localparam int CTRL_MODE_MSB   = 3;
  localparam int STATUS_WRAP_BIT = 1;
  localparam int CH_DUTY_LSB     = 0;
  localparam int CH_EN_BIT       = 16;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef struct packed {
    logic [27:0] rsvd;
    mode_e       mode;
    logic        commit;
    logic        global_en;
  } ctrl_t;

  typedef struct packed {
    logic [29:0] rsvd;
    logic        wrap_sticky;
    logic        pending;
  } status_t;

  // Duty field is sized for the widest supported PWM_WIDTH.
  typedef struct packed {
    logic [14:0] rsvd;
    logic        enable;
    logic [15:0] duty;
  } ch_cfg_t;

endpackage

// File: rtl/led_pwm_engine.sv
// Prescaler, PWM counter, blink phase and breathe ramp shared by all channels, with per-channel compare.
// Latency: hw output is one register after counter state; no backpressure, runs every cycle while enabled.
module led_pwm_engine
  import rgf_led_pwm_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int PWM_WIDTH   = 8,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              global_en,
  input  mode_e                             mode,
  input  logic [PRESC_WIDTH-1:0]            presc,
  input  logic [NUM_CH-1:0][PWM_WIDTH-1:0]  duty,
  input  logic [NUM_CH-1:0]                 enable,
  output logic                              wrap_tick,
  output logic [NUM_CH-1:0]                 led_out
);

  localparam logic [PWM_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [PWM_WIDTH-1:0]   CNT_ONE   = PWM_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

  logic [PRESC_WIDTH-1:0]           presc_cnt_q, presc_cnt_d;
  logic [PWM_WIDTH-1:0]             pwm_cnt_q, pwm_cnt_d;
  logic [PWM_WIDTH-1:0]             ramp_q, ramp_d;
  logic                             ramp_dn_q, ramp_dn_d;
  logic                             blink_q, blink_d;
  logic                             tick;
  logic [NUM_CH-1:0][PWM_WIDTH-1:0] eff_duty;
  logic [NUM_CH-1:0]                led_q, led_d;

  // Disabled engine parks every counter at zero so re-enable starts a fresh period.
  always_comb begin : counters
    tick        = global_en && (presc_cnt_q == '0);
    wrap_tick   = tick && (pwm_cnt_q == CNT_MAX);
    presc_cnt_d = '0;
    pwm_cnt_d   = '0;
    blink_d     = 1'b0;
    ramp_d      = '0;
    ramp_dn_d   = 1'b0;
    if (global_en) begin
      presc_cnt_d = tick ? presc : presc_cnt_q - PRESC_ONE;
      pwm_cnt_d   = tick ? pwm_cnt_q + CNT_ONE : pwm_cnt_q;
      blink_d     = blink_q ^ wrap_tick;
      ramp_d      = ramp_q;
      ramp_dn_d   = ramp_dn_q;
      if (wrap_tick) begin
        if (ramp_dn_q) begin
          if (ramp_q == '0) begin
            ramp_d    = ramp_q + CNT_ONE;
            ramp_dn_d = 1'b0;
          end else begin
            ramp_d = ramp_q - CNT_ONE;
          end
        end else begin
          if (ramp_q == CNT_MAX) begin
            ramp_d    = ramp_q - CNT_ONE;
            ramp_dn_d = 1'b1;
          end else begin
            ramp_d = ramp_q + CNT_ONE;
          end
        end
      end
    end
  end

  always_comb begin : compare
    eff_duty = duty;
    led_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mode == MODE_BREATHE && ramp_q < duty[i]) begin
        eff_duty[i] = ramp_q;
      end
      case (mode)
        MODE_STATIC: led_d[i] = 1'b1;
        MODE_BLINK:  led_d[i] = blink_q;
        default:     led_d[i] = (eff_duty[i] == CNT_MAX) || (pwm_cnt_q < eff_duty[i]);
      endcase
      led_d[i] = led_d[i] && enable[i] && global_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      ramp_q      <= '0;
      ramp_dn_q   <= 1'b0;
      blink_q     <= 1'b0;
      led_q       <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      ramp_q      <= ramp_d;
      ramp_dn_q   <= ramp_dn_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: rtl/rgf_led_pwm.sv
// LED register file: software shadow config, atomic commit to the active set at a PWM period boundary.
// Latency: combinational reads, writes visible next cycle; no backpressure, every selected strobe is accepted.
module rgf_led_pwm
  import rgf_led_pwm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 4,
  parameter int PWM_WIDTH   = 8,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  addr_decoder_leg,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [NUM_CH-1:0]     hw_led_out,
  output logic                  hw_pending
);

  localparam int XW = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;

  logic [XW-1:0]                    wd, rd;
  logic                             wr_sel, rd_sel;
  logic                             hit_ctrl, hit_presc, hit_status;
  logic [NUM_CH-1:0]                hit_ch;
  logic                             commit_req, load, wrap_tick;
  logic                             global_en_q, global_en_d;
  mode_e                            mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
  logic [PRESC_WIDTH-1:0]           presc_sh_q, presc_sh_d, presc_act_q, presc_act_d;
  logic [NUM_CH-1:0][PWM_WIDTH-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
  logic [NUM_CH-1:0]                en_sh_q, en_sh_d, en_act_q, en_act_d;
  logic                             pending_q, pending_d;
  logic                             wrap_sticky_q, wrap_sticky_d;
  ctrl_t                            ctrl_rd;
  status_t                          status_rd;
  ch_cfg_t                          ch_rd;
  logic                             unused_bits;

  assign wd          = XW'(wdata);
  assign wr_sel      = wr_en && addr_decoder_leg;
  assign rd_sel      = rd_en && addr_decoder_leg;
  assign unused_bits = ^{wd, rd};

  always_comb begin : decode
    hit_ctrl   = (addr == ADDR_WIDTH'(ADDR_CTRL));
    hit_presc  = (addr == ADDR_WIDTH'(ADDR_PRESC));
    hit_status = (addr == ADDR_WIDTH'(ADDR_STATUS));
    hit_ch     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit_ch[i] = (addr == ADDR_WIDTH'(ADDR_CH_BASE + CH_STRIDE * i));
    end
  end

  // A load clears pending on the same edge, so a commit landing with the load is dropped.
  always_comb begin : next_state
    global_en_d = global_en_q;
    mode_sh_d   = mode_sh_q;
    presc_sh_d  = presc_sh_q;
    duty_sh_d   = duty_sh_q;
    en_sh_d     = en_sh_q;
    if (wr_sel && hit_ctrl) begin
      global_en_d = wd[CTRL_EN_BIT];
      mode_sh_d   = mode_e'(wd[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    end
    if (wr_sel && hit_presc) presc_sh_d = wd[PRESC_WIDTH-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_sel && hit_ch[i]) begin
        duty_sh_d[i] = wd[CH_DUTY_LSB +: PWM_WIDTH];
        en_sh_d[i]   = wd[CH_EN_BIT];
      end
    end
    commit_req    = wr_sel && hit_ctrl && wd[CTRL_COMMIT_BIT];
    load          = pending_q && (wrap_tick || !global_en_q);
    pending_d     = load ? 1'b0 : (pending_q || commit_req);
    wrap_sticky_d = wrap_tick ||
                    (wrap_sticky_q && !(wr_sel && hit_status && wd[STATUS_WRAP_BIT]));
    mode_act_d    = load ? mode_sh_q  : mode_act_q;
    presc_act_d   = load ? presc_sh_q : presc_act_q;
    duty_act_d    = load ? duty_sh_q  : duty_act_q;
    en_act_d      = load ? en_sh_q    : en_act_q;
  end

  always_comb begin : read_mux
    ctrl_rd               = '0;
    ctrl_rd.global_en     = global_en_q;
    ctrl_rd.mode          = mode_sh_q;
    status_rd             = '0;
    status_rd.pending     = pending_q;
    status_rd.wrap_sticky = wrap_sticky_q;
    ch_rd                 = '0;
    rd                    = '0;
    if (rd_sel) begin
      if (hit_ctrl)   rd[31:0] = ctrl_rd;
      if (hit_presc)  rd[PRESC_WIDTH-1:0] = presc_sh_q;
      if (hit_status) rd[31:0] = status_rd;
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit_ch[i]) begin
          ch_rd.duty   = 16'(duty_sh_q[i]);
          ch_rd.enable = en_sh_q[i];
          rd[31:0]     = ch_rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      global_en_q   <= 1'b0;
      mode_sh_q     <= MODE_STATIC;
      mode_act_q    <= MODE_STATIC;
      presc_sh_q    <= '0;
      presc_act_q   <= '0;
      duty_sh_q     <= '0;
      duty_act_q    <= '0;
      en_sh_q       <= '0;
      en_act_q      <= '0;
      pending_q     <= 1'b0;
      wrap_sticky_q <= 1'b0;
    end else begin
      global_en_q   <= global_en_d;
      mode_sh_q     <= mode_sh_d;
      mode_act_q    <= mode_act_d;
      presc_sh_q    <= presc_sh_d;
      presc_act_q   <= presc_act_d;
      duty_sh_q     <= duty_sh_d;
      duty_act_q    <= duty_act_d;
      en_sh_q       <= en_sh_d;
      en_act_q      <= en_act_d;
      pending_q     <= pending_d;
      wrap_sticky_q <= wrap_sticky_d;
    end
  end

  led_pwm_engine #(
    .NUM_CH      (NUM_CH),
    .PWM_WIDTH   (PWM_WIDTH),
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .global_en (global_en_q),
    .mode      (mode_act_q),
    .presc     (presc_act_q),
    .duty      (duty_act_q),
    .enable    (en_act_q),
    .wrap_tick (wrap_tick),
    .led_out   (hw_led_out)
  );

  assign rdata      = rd[DATA_WIDTH-1:0];
  assign hw_pending = pending_q;

endmodule

// File: tb/tb_rgf_led_pwm.sv
// Directed register tests plus randomized LED configurations checked against an arithmetic model
// that derives counter state from the number of cycles elapsed since the engine was enabled.
module tb_rgf_led_pwm;

  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int NCH  = 4;
  localparam int PW   = 8;
  localparam int PSW  = 16;
  localparam int MAXV = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, rd_en, leg;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic [NCH-1:0] led;
  logic          pend;

  int checks   = 0;
  int failures = 0;

  // Model state: active config before (a_*) and after (b_*) a running commit lands at t_chg.
  int m_mode, m_presc, t_chg, t, s_w;
  int a_duty[NCH], b_duty[NCH];
  bit a_en[NCH], b_en[NCH];
  bit running;
  logic [31:0] r;
  int hi_cnt;

  always #5 clk = ~clk;

  rgf_led_pwm #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_CH (NCH), .PWM_WIDTH (PW), .PRESC_WIDTH (PSW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .addr (addr), .wr_en (wr_en), .rd_en (rd_en), .wdata (wdata),
    .addr_decoder_leg (leg), .rdata (rdata), .hw_led_out (led), .hw_pending (pend)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tri_wave(input int w);
    int k;
    k = w % (2 * MAXV);
    return (k <= MAXV) ? k : 2 * MAXV - k;
  endfunction

  // LED value computed from counter state s cycles after enable.
  function automatic logic [NCH-1:0] model_led(input int s);
    logic [NCH-1:0] res;
    int nt, cnt, wraps, d, e;
    bit en, v;
    res   = '0;
    nt    = (s + m_presc) / (m_presc + 1);
    cnt   = nt % (MAXV + 1);
    wraps = nt / (MAXV + 1);
    for (int ch = 0; ch < NCH; ch++) begin
      d  = (s >= t_chg) ? b_duty[ch] : a_duty[ch];
      en = (s >= t_chg) ? b_en[ch]   : a_en[ch];
      case (m_mode)
        0:       v = 1'b1;
        1:       v = (d == MAXV) || (cnt < d);
        2:       v = (wraps % 2) == 1;
        default: begin
          e = (d < tri_wave(wraps)) ? d : tri_wave(wraps);
          v = (e == MAXV) || (cnt < e);
        end
      endcase
      res[ch] = en && v;
    end
    return res;
  endfunction

  task automatic step();
    @(negedge clk);
    if (running) begin
      t++;
      chk("led", 32'(led), (t == 0) ? 32'd0 : 32'(model_led(t - 1)));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr  = AW'(a);
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    addr  = AW'(a);
    rd_en = 1'b1;
    #1;
    d     = rdata;
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] ch_word(input int ch);
    return (32'(a_en[ch]) << 16) | 32'(a_duty[ch]);
  endfunction

  function automatic int pick_duty();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return MAXV;
      default: return int'($urandom_range(1, MAXV - 1));
    endcase
  endfunction

  // Disable, program shadows from a_*/m_*, commit while disabled, then enable.
  task automatic configure();
    logic [31:0] rv;
    running = 1'b0;
    wr('h00, 32'd0);
    wr('h04, 32'(m_presc));
    for (int ch = 0; ch < NCH; ch++) wr('h10 + 4 * ch, ch_word(ch));
    chk("led_disabled", 32'(led), 32'd0);
    rd('h10, rv);
    chk("ch0_shadow", rv, ch_word(0));
    rd('h04, rv);
    chk("presc_shadow", rv, 32'(m_presc));
    wr('h00, 32'((m_mode << 2) | 2));
    chk("pend_set", 32'(pend), 32'd1);
    t_chg   = 1 << 30;
    t       = -1;
    running = 1'b1;
    wr('h00, 32'((m_mode << 2) | 1));
    chk("pend_clr", 32'(pend), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; leg = 1'b1; addr = '0; wdata = '0;
    running = 1'b0; t = 0; t_chg = 1 << 30; m_mode = 0; m_presc = 0;
    for (int ch = 0; ch < NCH; ch++) begin a_duty[ch] = 0; a_en[ch] = 0; b_duty[ch] = 0; b_en[ch] = 0; end
    run(3);
    rst_n = 1'b1;
    step();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    for (int a = 0; a <= 'h1C; a += 4) begin
      rd(a, r);
      chk("rst_read", r, 32'd0);
    end

    leg = 1'b0;
    wr('h18, 32'h0001_00FF);
    leg = 1'b1;
    rd('h18, r);
    chk("leg_gates_wr", r, 32'd0);

    // STATIC on channel 0
    a_en[0] = 1'b1;
    configure();
    step();
    chk("static_led0", 32'(led[0]), 32'd1);
    rd('h00, r);
    chk("ctrl_read", r, 32'd1);
    rd('h11, r);
    chk("misaligned_read", r, 32'd0);
    leg = 1'b0;
    rd('h00, r);
    leg = 1'b1;
    chk("leg_gates_rd", r, 32'd0);
    run(20);

    // PWM, duty 64 on channel 1, wrap_sticky, then running commit to 192
    m_mode = 1; m_presc = 0;
    a_duty[0] = 0; a_duty[1] = 64; a_duty[2] = MAXV; a_duty[3] = 10;
    a_en[0] = 1; a_en[1] = 1; a_en[2] = 1; a_en[3] = 0;
    configure();
    run(3);
    wr('h08, 32'h2);
    rd('h08, r);
    chk("sticky_cleared", r, 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led[1]) hi_cnt++;
    end
    chk("pwm_high_count", 32'(hi_cnt), 32'd64);
    rd('h08, r);
    chk("sticky_set", r, 32'h2);
    wr('h08, 32'h2);
    rd('h08, r);
    chk("sticky_w1c", r, 32'd0);
    for (int ch = 0; ch < NCH; ch++) begin b_duty[ch] = a_duty[ch]; b_en[ch] = a_en[ch]; end
    b_duty[1] = 192;
    wr('h14, 32'h0001_00C0);
    rd('h14, r);
    chk("ch1_shadow_new", r, 32'h0001_00C0);
    wr('h00, 32'h7);
    s_w   = (t / 256) * 256 + 255;
    t_chg = s_w + 1;
    chk("pend_running", 32'(pend), 32'd1);
    rd('h08, r);
    chk("status_pending", r, 32'h1);
    wr('h00, 32'h7);
    chk("pend_recommit", 32'(pend), 32'd1);
    while (t < s_w) step();
    chk("pend_hold", 32'(pend), 32'd1);
    step();
    chk("pend_drop", 32'(pend), 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led[1]) hi_cnt++;
    end
    chk("pwm_new_count", 32'(hi_cnt), 32'd192);

    // BLINK with prescaler 1: 512-cycle phases
    m_mode = 2; m_presc = 1; t_chg = 1 << 30;
    for (int ch = 0; ch < NCH; ch++) begin a_duty[ch] = pick_duty(); a_en[ch] = (ch != 1); end
    configure();
    run(1100);

    // BREATHE: ramp grows by one per wrap
    m_mode = 3; m_presc = 0;
    a_duty[0] = MAXV; a_duty[1] = 5; a_duty[2] = 0; a_duty[3] = 100;
    for (int ch = 0; ch < NCH; ch++) a_en[ch] = 1'b1;
    configure();
    run(3600);

    for (int k = 0; k < 4; k++) begin
      m_mode  = int'($urandom_range(0, 3));
      m_presc = int'($urandom_range(0, 2));
      for (int ch = 0; ch < NCH; ch++) begin
        a_duty[ch] = pick_duty();
        a_en[ch]   = 1'($urandom_range(0, 1));
      end
      configure();
      run(1600);
    end

    // Reset while a commit is pending
    m_mode = 1; m_presc = 0;
    for (int ch = 0; ch < NCH; ch++) begin a_duty[ch] = 128; a_en[ch] = 1'b1; end
    configure();
    run(10);
    wr('h04, 32'h5);
    wr('h00, 32'h7);
    chk("pend_before_rst", 32'(pend), 32'd1);
    running = 1'b0;
    rst_n   = 1'b0;
    step();
    chk("rst_pend_clear", 32'(pend), 32'd0);
    chk("rst_led_clear", 32'(led), 32'd0);
    rd('h04, r);
    chk("rst_presc_clear", r, 32'd0);
    rd('h10, r);
    chk("rst_ch0_clear", r, 32'd0);
    rst_n = 1'b1;
    step();
    wr('h10, 32'h0001_0000);
    m_mode = 0;
    for (int ch = 0; ch < NCH; ch++) begin a_duty[ch] = 0; a_en[ch] = 1'b0; end
    t_chg   = 1 << 30;
    t       = -1;
    running = 1'b1;
    wr('h00, 32'h1);
    run(600);
    chk("no_load_after_rst", 32'(pend), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
